// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage. These must track the decode stage's op bus.
package ex_stage_pkg;

    localparam int EX_OP_BUS = 8;

    localparam logic [2:0] EX_HIGH_SPECIAL = 3'd0;
    localparam logic [2:0] EX_HIGH_LOGIC   = 3'd1;
    localparam logic [2:0] EX_HIGH_ARITH   = 3'd2;
    localparam logic [2:0] EX_HIGH_SHIFT   = 3'd3;
    localparam logic [2:0] EX_HIGH_MUL     = 3'd4;
    localparam logic [2:0] EX_HIGH_MEM     = 3'd5;

    localparam logic [4:0] EX_LOW_OR   = 5'd0;
    localparam logic [4:0] EX_LOW_AND  = 5'd1;
    localparam logic [4:0] EX_LOW_XOR  = 5'd2;
    localparam logic [4:0] EX_LOW_NOR  = 5'd3;
    localparam logic [4:0] EX_LOW_LUI  = 5'd4;
    localparam logic [4:0] EX_LOW_ADDU = 5'd0;
    localparam logic [4:0] EX_LOW_SUBU = 5'd1;
    localparam logic [4:0] EX_LOW_SLT  = 5'd2;
    localparam logic [4:0] EX_LOW_SLTU = 5'd3;
    localparam logic [4:0] EX_LOW_SLL  = 5'd0;
    localparam logic [4:0] EX_LOW_SRL  = 5'd1;
    localparam logic [4:0] EX_LOW_SRA  = 5'd2;
    localparam logic [4:0] EX_LOW_MULU = 5'd0;
    localparam logic [4:0] EX_LOW_LW   = 5'd0;
    localparam logic [4:0] EX_LOW_SW   = 5'd1;

    localparam logic [EX_OP_BUS-1:0] EX_OP_NOP = 8'h00;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic        ENABLE    = 1'b1;
    localparam logic        DISABLE   = 1'b0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/ex_iter_mul.sv
// Iterative shift-add multiplier retiring MUL_STEP_BITS multiplier bits per cycle.
module ex_iter_mul
    import ex_stage_pkg::*;
#(
    parameter int MUL_STEP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand_in,
    input  logic [31:0] mplier_in,
    output logic [1:0]  state,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    localparam int STEPS = 32 / MUL_STEP_BITS;
    localparam int CNT_W = $clog2(STEPS + 1);

    mul_state_t       state_q, state_d;
    logic [31:0]      acc, mcand, mplier, partial;
    logic [CNT_W-1:0] cnt;

    // Partial product of this step: mcand times the low MUL_STEP_BITS of mplier.
    always_comb begin
        partial = ZERO_WORD;
        for (int i = 0; i < MUL_STEP_BITS; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: if (start) state_d = MUL_RUN;
            MUL_RUN:  if (cnt == CNT_W'(1)) state_d = MUL_DONE;
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            acc     <= ZERO_WORD;
            mcand   <= ZERO_WORD;
            mplier  <= ZERO_WORD;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == MUL_IDLE && start) begin
                acc    <= ZERO_WORD;
                mcand  <= mcand_in;
                mplier <= mplier_in;
                cnt    <= CNT_W'(STEPS);
            end else if (state_q == MUL_RUN) begin
                acc    <= acc + partial;
                mcand  <= mcand << MUL_STEP_BITS;
                mplier <= mplier >> MUL_STEP_BITS;
                cnt    <= cnt - CNT_W'(1);
            end
        end
    end

    assign state   = state_q;
    assign busy    = (state_q == MUL_RUN);
    assign done    = (state_q == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX latch, inline ALU, forwarding outputs and an iterative multiplier.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int MUL_STEP_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_exop,
    input  logic [31:0] i_srcLeft,
    input  logic [31:0] i_srcRight,
    input  logic [31:0] i_offset,
    input  logic [4:0]  i_dest,
    input  logic        i_stall,
    output logic [4:0]  o_dest,
    output logic [31:0] o_result,
    output logic        o_writeEnable,
    output logic [31:0] o_offset,
    output logic        o_memOp,
    output logic        o_busy
);

    logic [EX_OP_BUS-1:0] ex_op;
    logic [31:0]          src_left, src_right, offset_q;
    logic [4:0]           dest_q;
    logic [2:0]           op_class;
    logic [4:0]           op_sub, shamt;
    logic                 is_mul, mul_start, mul_busy, mul_done;
    logic [1:0]           mul_state;
    logic [31:0]          mul_product, alu_result;
    logic                 alu_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_op     <= EX_OP_NOP;
            src_left  <= ZERO_WORD;
            src_right <= ZERO_WORD;
            offset_q  <= ZERO_WORD;
            dest_q    <= REG_ZERO;
        end else if (!o_busy) begin
            if (i_stall) begin
                ex_op     <= EX_OP_NOP;
                src_left  <= ZERO_WORD;
                src_right <= ZERO_WORD;
                offset_q  <= ZERO_WORD;
                dest_q    <= REG_ZERO;
            end else begin
                ex_op     <= i_exop;
                src_left  <= i_srcLeft;
                src_right <= i_srcRight;
                offset_q  <= i_offset;
                dest_q    <= i_dest;
            end
        end
    end

    assign op_class = ex_op[7:5];
    assign op_sub   = ex_op[4:0];
    assign shamt    = src_left[4:0];
    assign is_mul   = (op_class == EX_HIGH_MUL) && (op_sub == EX_LOW_MULU);
    // A MUL sitting in the latch while the FSM is idle was latched this cycle.
    assign mul_start = is_mul && (mul_state == MUL_IDLE);
    assign o_busy    = mul_start || mul_busy;

    ex_iter_mul #(.MUL_STEP_BITS(MUL_STEP_BITS)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start     (mul_start),
        .mcand_in  (src_left),
        .mplier_in (src_right),
        .state     (mul_state),
        .busy      (mul_busy),
        .done      (mul_done),
        .product   (mul_product)
    );

    always_comb begin
        alu_result = ZERO_WORD;
        alu_we     = DISABLE;
        case (op_class)
            EX_HIGH_LOGIC: begin
                alu_we = ENABLE;
                case (op_sub)
                    EX_LOW_OR:  alu_result = src_left | src_right;
                    EX_LOW_AND: alu_result = src_left & src_right;
                    EX_LOW_XOR: alu_result = src_left ^ src_right;
                    EX_LOW_NOR: alu_result = ~(src_left | src_right);
                    EX_LOW_LUI: alu_result = {src_right[15:0], 16'h0000};
                    default:    alu_we = DISABLE;
                endcase
            end
            EX_HIGH_ARITH: begin
                alu_we = ENABLE;
                case (op_sub)
                    EX_LOW_ADDU: alu_result = src_left + src_right;
                    EX_LOW_SUBU: alu_result = src_left - src_right;
                    EX_LOW_SLT:  alu_result = {31'b0, $signed(src_left) < $signed(src_right)};
                    EX_LOW_SLTU: alu_result = {31'b0, src_left < src_right};
                    default:     alu_we = DISABLE;
                endcase
            end
            EX_HIGH_SHIFT: begin
                alu_we = ENABLE;
                case (op_sub)
                    EX_LOW_SLL: alu_result = src_right << shamt;
                    EX_LOW_SRL: alu_result = src_right >> shamt;
                    EX_LOW_SRA: alu_result = $unsigned($signed(src_right) >>> shamt);
                    default:    alu_we = DISABLE;
                endcase
            end
            EX_HIGH_MUL: begin
                if (is_mul && mul_done) begin
                    alu_result = mul_product;
                    alu_we     = ENABLE;
                end
            end
            EX_HIGH_MEM: begin
                // Address only; the loaded value is forwarded later by MEM.
                if (op_sub == EX_LOW_LW || op_sub == EX_LOW_SW) begin
                    alu_result = src_left + offset_q;
                end
            end
            default: begin
                alu_result = ZERO_WORD;
                alu_we     = DISABLE;
            end
        endcase
    end

    assign o_result      = alu_result;
    assign o_writeEnable = alu_we && (dest_q != REG_ZERO);
    assign o_dest        = dest_q;
    assign o_offset      = offset_q;
    assign o_memOp       = (op_class == EX_HIGH_MEM) &&
                           (op_sub == EX_LOW_LW || op_sub == EX_LOW_SW);

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: reference model feeds an expected queue popped one clock later.
module tb_ex_stage;
    import ex_stage_pkg::*;

    localparam int W = 72;  // {busy, dest[4:0], we, memop, offset[31:0], result[31:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_exop;
    logic [31:0] i_srcLeft, i_srcRight, i_offset;
    logic [4:0]  i_dest;
    logic        i_stall;
    logic [4:0]  o_dest;
    logic [31:0] o_result, o_offset;
    logic        o_writeEnable, o_memOp, o_busy;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    ex_stage #(.MUL_STEP_BITS(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_exop        (i_exop),
        .i_srcLeft     (i_srcLeft),
        .i_srcRight    (i_srcRight),
        .i_offset      (i_offset),
        .i_dest        (i_dest),
        .i_stall       (i_stall),
        .o_dest        (o_dest),
        .o_result      (o_result),
        .o_writeEnable (o_writeEnable),
        .o_offset      (o_offset),
        .o_memOp       (o_memOp),
        .o_busy        (o_busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(logic busy, logic [4:0] d, logic we, logic mem,
                                          logic [31:0] off, logic [31:0] res);
        return {busy, d, we, mem, off, res};
    endfunction

    // Reference model of one single-cycle op as seen the cycle after it is presented.
    function automatic logic [W-1:0] model(logic [7:0] op, logic [31:0] l, logic [31:0] r,
                                           logic [31:0] off, logic [4:0] d, logic stall);
        logic [31:0] res;
        logic        valid, mem;
        logic [4:0]  a;
        res = 32'h0; valid = 1'b0; mem = 1'b0; a = l[4:0];
        if (stall) return pack(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
        case (op)
            {EX_HIGH_LOGIC, EX_LOW_OR}:   begin res = l | r; valid = 1'b1; end
            {EX_HIGH_LOGIC, EX_LOW_AND}:  begin res = l & r; valid = 1'b1; end
            {EX_HIGH_LOGIC, EX_LOW_XOR}:  begin res = l ^ r; valid = 1'b1; end
            {EX_HIGH_LOGIC, EX_LOW_NOR}:  begin res = ~(l | r); valid = 1'b1; end
            {EX_HIGH_LOGIC, EX_LOW_LUI}:  begin res = r << 16; valid = 1'b1; end
            {EX_HIGH_ARITH, EX_LOW_ADDU}: begin res = l + r; valid = 1'b1; end
            {EX_HIGH_ARITH, EX_LOW_SUBU}: begin res = l - r; valid = 1'b1; end
            {EX_HIGH_ARITH, EX_LOW_SLT}: begin
                if (l[31] != r[31]) res = {31'b0, l[31]};
                else res = {31'b0, l < r};
                valid = 1'b1;
            end
            {EX_HIGH_ARITH, EX_LOW_SLTU}: begin res = {31'b0, l < r}; valid = 1'b1; end
            {EX_HIGH_SHIFT, EX_LOW_SLL}:  begin res = r << a; valid = 1'b1; end
            {EX_HIGH_SHIFT, EX_LOW_SRL}:  begin res = r >> a; valid = 1'b1; end
            {EX_HIGH_SHIFT, EX_LOW_SRA}: begin
                res = (r >> a) | (r[31] ? ~(32'hFFFF_FFFF >> a) : 32'h0);
                valid = 1'b1;
            end
            {EX_HIGH_MEM, EX_LOW_LW}, {EX_HIGH_MEM, EX_LOW_SW}: begin res = l + off; mem = 1'b1; end
            default: res = 32'h0;
        endcase
        return pack(1'b0, d, valid && (d != 5'd0), mem, off, res);
    endfunction

    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: expected queue empty, got result %h", tag, o_result);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".busy"},   {31'b0, o_busy},        {31'b0, e[71]});
        check({tag, ".dest"},   {27'b0, o_dest},        {27'b0, e[70:66]});
        check({tag, ".we"},     {31'b0, o_writeEnable}, {31'b0, e[65]});
        check({tag, ".memop"},  {31'b0, o_memOp},       {31'b0, e[64]});
        check({tag, ".offset"}, o_offset,               e[63:32]);
        check({tag, ".result"}, o_result,               e[31:0]);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [7:0] op, input logic [31:0] l, input logic [31:0] r,
                         input logic [31:0] off, input logic [4:0] d, input logic stall);
        i_exop = op; i_srcLeft = l; i_srcRight = r; i_offset = off; i_dest = d; i_stall = stall;
    endtask

    task automatic apply(input string tag, input logic [7:0] op, input logic [31:0] l,
                         input logic [31:0] r, input logic [31:0] off, input logic [4:0] d,
                         input logic stall);
        drive(op, l, r, off, d, stall);
        exp_q.push_back(model(op, l, r, off, d, stall));
        @(posedge clk); #1;
        pop_check(tag);
    endtask

    task automatic drive_random;
        drive(8'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom_range(0, 1)));
    endtask

    // MULU with latch-hold checks while busy; rst_at >= 0 injects reset in that busy cycle.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input int rst_at);
        logic [31:0] p;
        p = a * b;
        drive({EX_HIGH_MUL, EX_LOW_MULU}, a, b, 32'h0, d, 1'b0);
        exp_q.push_back(pack(1'b0, d, d != 5'd0, 1'b0, 32'h0, p));
        @(posedge clk); #1;
        for (int i = 0; i < 33; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                void'(exp_q.pop_back());
                exp_q.push_back(pack(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0));
                pop_check({tag, ".rst"});
                drive(EX_OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b1);
                for (int k = 0; k < 40; k++) begin
                    check({tag, ".post_rst_we"},   {31'b0, o_writeEnable}, 32'd0);
                    check({tag, ".post_rst_busy"}, {31'b0, o_busy},        32'd0);
                    @(posedge clk); #1;
                end
                return;
            end
            check({tag, ".busy"},    {31'b0, o_busy},        32'd1);
            check({tag, ".we_busy"}, {31'b0, o_writeEnable}, 32'd0);
            check({tag, ".hold"},    {27'b0, o_dest},        {27'b0, d});
            drive_random();
            @(posedge clk); #1;
        end
        pop_check({tag, ".done"});
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] ops[12] = '{
        {EX_HIGH_LOGIC, EX_LOW_OR},   {EX_HIGH_LOGIC, EX_LOW_AND},  {EX_HIGH_LOGIC, EX_LOW_XOR},
        {EX_HIGH_LOGIC, EX_LOW_NOR},  {EX_HIGH_LOGIC, EX_LOW_LUI},  {EX_HIGH_ARITH, EX_LOW_ADDU},
        {EX_HIGH_ARITH, EX_LOW_SUBU}, {EX_HIGH_ARITH, EX_LOW_SLT},  {EX_HIGH_ARITH, EX_LOW_SLTU},
        {EX_HIGH_SHIFT, EX_LOW_SLL},  {EX_HIGH_SHIFT, EX_LOW_SRL},  {EX_HIGH_SHIFT, EX_LOW_SRA}
    };

    initial begin
        rst = 1'b1;
        drive(EX_OP_NOP, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(pack(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0));
        pop_check("reset");
        rst = 1'b0;

        // Reset mid-stream with an ORI-like op presented.
        apply("or_pre", {EX_HIGH_LOGIC, EX_LOW_OR}, 32'h1, 32'h2, 32'h0, 5'd4, 1'b0);
        drive({EX_HIGH_LOGIC, EX_LOW_OR}, 32'h0000_1234, 32'h0000_00FF, 32'h0, 5'd9, 1'b0);
        rst = 1'b1;
        exp_q.push_back(pack(1'b0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0));
        @(posedge clk); #1;
        rst = 1'b0;
        pop_check("rst_mid");

        apply("or_d8", {EX_HIGH_LOGIC, EX_LOW_OR}, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 5'd8, 1'b0);
        apply("or_d0", {EX_HIGH_LOGIC, EX_LOW_OR}, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0, 5'd0, 1'b0);
        apply("slt",   {EX_HIGH_ARITH, EX_LOW_SLT},  32'hFFFF_FFFF, 32'h1, 32'h0, 5'd5, 1'b0);
        apply("sltu",  {EX_HIGH_ARITH, EX_LOW_SLTU}, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd5, 1'b0);
        apply("subu",  {EX_HIGH_ARITH, EX_LOW_SUBU}, 32'h0, 32'h1, 32'h0, 5'd6, 1'b0);
        apply("stall", {EX_HIGH_ARITH, EX_LOW_ADDU}, 32'h5, 32'h6, 32'h10, 5'd7, 1'b1);
        apply("sra",   {EX_HIGH_SHIFT, EX_LOW_SRA},  32'd31, 32'h8000_0000, 32'h0, 5'd2, 1'b0);
        apply("undef_class", 8'hC1, 32'h3, 32'h4, 32'h0, 5'd3, 1'b0);
        apply("undef_mul",   {EX_HIGH_MUL, 5'd1}, 32'h3, 32'h4, 32'h0, 5'd3, 1'b0);
        apply("lw", {EX_HIGH_MEM, EX_LOW_LW}, 32'h100, 32'h0, 32'hFFFF_FFFC, 5'd10, 1'b0);
        apply("sw", {EX_HIGH_MEM, EX_LOW_SW}, 32'h200, 32'h55, 32'h0000_0010, 5'd0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            apply("rand_alu", ops[$urandom_range(0, 11)], $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 7) == 0));
        end

        do_mul("mul1", 32'h0001_2345, 32'h0000_0100, 5'd3, -1);
        // Second MUL latched on the DONE-exit clock.
        do_mul("mul2", $urandom, $urandom, 5'd12, -1);
        apply("addu_after_mul", {EX_HIGH_ARITH, EX_LOW_ADDU}, 32'h7, 32'h9, 32'h0, 5'd11, 1'b0);
        do_mul("mul_d0", 32'h0000_0003, 32'h0000_0005, 5'd0, -1);
        do_mul("mul_rst", 32'h0001_2345, 32'h0000_0100, 5'd3, 10);
        apply("or_after_rst", {EX_HIGH_LOGIC, EX_LOW_OR}, 32'hA0, 32'h0B, 32'h0, 5'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
